// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - multicycle branch/jump sequencer with taken/not-taken counters
module branch_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_kind_i,
    input  logic [2:0]       req_funct3_i,
    input  logic [XLEN-1:0]  req_pc_i,
    input  logic [XLEN-1:0]  req_rs1_i,
    input  logic [XLEN-1:0]  req_rs2_i,
    input  logic [XLEN-1:0]  req_imm_i,
    input  logic             abort_i,
    output logic [XLEN-1:0]  bu_a_o,
    output logic [XLEN-1:0]  bu_b_o,
    output logic [2:0]       bu_funct3_o,
    output logic             bu_en_o,
    input  logic             bu_branch_i,
    output logic             pc_we_o,
    output logic [XLEN-1:0]  pc_next_o,
    output logic             rd_we_o,
    output logic [XLEN-1:0]  rd_data_o,
    output logic             misalign_o,
    output logic             done_o,
    output logic [CNT_W-1:0] taken_cnt_o,
    output logic [CNT_W-1:0] ntaken_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_TARGET, S_COMMIT} state_t;

    localparam logic [1:0] K_BRANCH = 2'd0;
    localparam logic [1:0] K_JAL    = 2'd1;
    localparam logic [1:0] K_JALR   = 2'd2;
    localparam logic [1:0] K_RSVD   = 2'd3;

    state_t            state_q, state_d;
    logic [1:0]        kind_q;
    logic [2:0]        funct3_q;
    logic [XLEN-1:0]   pc_q, rs1_q, rs2_q, imm_q;
    logic [XLEN-1:0]   next_q, link_q, tgt;
    logic              taken_q, mis_q;
    logic [CNT_W-1:0]  taken_cnt_q, ntaken_cnt_q;
    logic              accept;

    assign accept = (state_q == S_IDLE) && req_valid_i && !abort_i;

    // JALR clears bit 0 of the sum; branches and JAL are PC-relative
    assign tgt = (kind_q == K_JALR) ? ((rs1_q + imm_q) & {{(XLEN-1){1'b1}}, 1'b0})
                                    : (pc_q + imm_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        bu_en_o     = 1'b0;
        done_o      = 1'b0;
        pc_we_o     = 1'b0;
        rd_we_o     = 1'b0;
        misalign_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = !abort_i;
                if (req_valid_i && !abort_i) state_d = S_EVAL;
            end
            S_EVAL: begin
                bu_en_o = (kind_q == K_BRANCH);
                state_d = abort_i ? S_IDLE : S_TARGET;
            end
            S_TARGET: state_d = abort_i ? S_IDLE : S_COMMIT;
            S_COMMIT: begin
                done_o     = 1'b1;
                misalign_o = mis_q;
                pc_we_o    = !mis_q && (kind_q != K_RSVD);
                rd_we_o    = !mis_q && ((kind_q == K_JAL) || (kind_q == K_JALR));
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            kind_q       <= K_BRANCH;
            funct3_q     <= 3'd0;
            pc_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            imm_q        <= '0;
            taken_q      <= 1'b0;
            mis_q        <= 1'b0;
            next_q       <= '0;
            link_q       <= '0;
            taken_cnt_q  <= '0;
            ntaken_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    kind_q   <= req_kind_i;
                    funct3_q <= req_funct3_i;
                    pc_q     <= req_pc_i;
                    rs1_q    <= req_rs1_i;
                    rs2_q    <= req_rs2_i;
                    imm_q    <= req_imm_i;
                end
                S_EVAL: taken_q <= (kind_q == K_BRANCH) ? bu_branch_i : (kind_q != K_RSVD);
                S_TARGET: begin
                    next_q <= taken_q ? tgt : (pc_q + XLEN'(4));
                    link_q <= pc_q + XLEN'(4);
                    mis_q  <= taken_q && (tgt[1:0] != 2'b00);
                end
                S_COMMIT: if (!mis_q) begin
                    if (taken_q && (kind_q != K_RSVD)) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
                    if ((kind_q == K_BRANCH) && !taken_q) ntaken_cnt_q <= ntaken_cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bu_a_o       = rs1_q;
    assign bu_b_o       = rs2_q;
    assign bu_funct3_o  = funct3_q;
    assign pc_next_o    = next_q;
    assign rd_data_o    = link_q;
    assign taken_cnt_o  = taken_cnt_q;
    assign ntaken_cnt_o = ntaken_cnt_q;

endmodule
